int_tx_arbiter: RTL and testbench

- Shares one int_sender (32-bit word → 4 UART bytes, LSB first) among N_REQ independent requesters.
- Each requester has a 1-deep holding slot. A round-robin scheduler grants one full slot at a time.
- Optionally prefixes each data word with a tagged header word (magic, source id, sequence number).
- Sits between the command/telemetry producers and int_sender, and drives int_sender's int_send/int_ready handshake.

---
 rtl/tx_arb_pkg.sv | 27 ++
 rtl/int_tx_arbiter_rr_picker.sv | 33 +++
 rtl/int_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_int_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the int_sender round-robin arbiter.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  typedef enum logic {
    PH_HDR  = 1'b0,
    PH_DATA = 1'b1
  } phase_t;

  localparam logic [7:0] HDR_MAGIC_DEF = 8'hA5;

  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_ID_LSB    = 16;
  localparam int HDR_SEQ_LSB   = 0;

  // Header word: magic in [31:24], source id in [18:16], sequence number in [15:0].
  function automatic logic [31:0] make_hdr(input logic [7:0] magic, input logic [2:0] id,
                                           input logic [15:0] seq_num);
    return (32'(magic) << HDR_MAGIC_LSB) | (32'(id) << HDR_ID_LSB) | (32'(seq_num) << HDR_SEQ_LSB);
  endfunction

endpackage

// File: rtl/int_tx_arbiter_rr_picker.sv
// Combinational round-robin pick: first full slot at or after rr_ptr, wrapping modulo N_REQ.
module rr_picker
  import tx_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] slot_full,
  input  logic [2:0]       rr_ptr,
  output logic             any_full,
  output logic [2:0]       grant
);

  logic [7:0] full_ext;
  logic [3:0] idx;

  assign full_ext = 8'(slot_full);

  always_comb begin
    any_full = 1'b0;
    grant    = 3'd0;
    idx      = 4'd0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      // rr_ptr < N_REQ and k < N_REQ, so one subtraction is a full modulo
      if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
      if (!any_full && full_ext[idx[2:0]]) begin
        any_full = 1'b1;
        grant    = idx[2:0];
      end
    end
  end

endmodule

// File: rtl/int_tx_arbiter.sv
// Shares one int_sender among N_REQ 1-deep slots, round-robin, optionally prefixing a tagged header word.
// int_send rises one cycle after a slot fills when int_sender is idle; req_ready stays low while a slot waits.
module int_tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int         N_REQ     = 4,
  parameter bit         TAG_EN    = 1'b1,
  parameter logic [7:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          int_data,
  output logic                 int_send,
  input  logic                 int_ready,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 word_done,
  output logic [15:0]          seq
);

  state_t           state;
  phase_t           phase;
  logic [N_REQ-1:0] slot_full;
  logic [31:0]      slot_dat [N_REQ];
  logic [2:0]       rr_ptr;
  logic             any_full;
  logic [2:0]       grant;
  logic [31:0]      grant_dat;
  logic [31:0]      held_dat;
  logic             do_grant;
  logic             do_done;

  assign req_ready = ~slot_full;
  assign busy      = (state != ST_IDLE);
  // The int_ready gate in IDLE also covers a byte train still draining after reset.
  assign do_grant  = (state == ST_IDLE) && int_ready && any_full;
  assign do_done   = (state == ST_WAIT_DONE) && int_ready && (phase == PH_DATA);

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .slot_full (slot_full),
    .rr_ptr    (rr_ptr),
    .any_full  (any_full),
    .grant     (grant)
  );

  always_comb begin
    grant_dat = '0;
    held_dat  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == 3'(i))    grant_dat = slot_dat[i];
      if (grant_id == 3'(i)) held_dat  = slot_dat[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) begin
        slot_full[i] <= 1'b0;
      end else if (req_valid[i] && !slot_full[i]) begin
        slot_full[i] <= 1'b1;
        slot_dat[i]  <= req_data[32*i +: 32];
      end else if (do_done && (grant_id == 3'(i))) begin
        slot_full[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= PH_HDR;
      int_send  <= 1'b0;
      int_data  <= 32'd0;
      grant_id  <= 3'd0;
      rr_ptr    <= 3'd0;
      word_done <= 1'b0;
      seq       <= 16'd0;
    end else begin
      word_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (do_grant) begin
            state    <= ST_ISSUE;
            int_send <= 1'b1;
            grant_id <= grant;
            rr_ptr   <= (grant == 3'(N_REQ-1)) ? 3'd0 : grant + 3'd1;
            if (TAG_EN) begin
              phase    <= PH_HDR;
              int_data <= make_hdr(HDR_MAGIC, grant, seq);
            end else begin
              phase    <= PH_DATA;
              int_data <= grant_dat;
            end
          end
        end
        ST_ISSUE: begin
          if (!int_ready) begin
            int_send <= 1'b0;
            state    <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (int_ready) begin
            if (phase == PH_HDR) begin
              phase    <= PH_DATA;
              int_data <= held_dat;
              int_send <= 1'b1;
              state    <= ST_ISSUE;
            end else begin
              seq       <= seq + 16'd1;
              word_done <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_tx_arbiter.sv
// Bench for int_tx_arbiter: a tagged instance under directed and random waves, and an untagged instance.
module tb_int_tx_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]   req_valid0, req_ready0, req_valid1, req_ready1;
  logic [127:0] req_data0, req_data1;
  logic [31:0]  int_data0, int_data1;
  logic         int_send0, int_send1, int_ready0, int_ready1;
  logic         busy0, busy1, word_done0, word_done1;
  logic [2:0]   grant_id0, grant_id1;
  logic [15:0]  seq0, seq1;

  int_tx_arbiter #(.N_REQ(4), .TAG_EN(1'b1), .HDR_MAGIC(8'hA5)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_data(req_data0), .req_ready(req_ready0),
    .int_data(int_data0), .int_send(int_send0), .int_ready(int_ready0), .busy(busy0),
    .grant_id(grant_id0), .word_done(word_done0), .seq(seq0));

  int_tx_arbiter #(.N_REQ(4), .TAG_EN(1'b0), .HDR_MAGIC(8'hA5)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_data(req_data1), .req_ready(req_ready1),
    .int_data(int_data1), .int_send(int_send1), .int_ready(int_ready1), .busy(busy1),
    .grant_id(grant_id1), .word_done(word_done1), .seq(seq1));

  int total = 0;
  int bad = 0;

  // int_sender stand-ins: accept a word when idle, log its bytes LSB first, stay busy a random time.
  int   cnt0 = 0, cnt1 = 0, acc0 = 0, done0 = 0, done1 = 0;
  logic hold0 = 1'b0;
  logic [7:0] got0[$], got1[$], exp0[$];
  int   gid0[$], gid_exp0[$];

  assign int_ready0 = (cnt0 == 0) && !hold0;
  assign int_ready1 = (cnt1 == 0);

  always @(negedge clk) begin
    if (cnt0 != 0) cnt0--;
    else if (int_send0 && !hold0) begin
      for (int b = 0; b < 4; b++) got0.push_back(int_data0[8*b +: 8]);
      cnt0 = $urandom_range(1, 5);
      acc0++;
    end
    if (word_done0) begin
      done0++;
      gid0.push_back(int'(grant_id0));
    end
  end

  always @(negedge clk) begin
    if (cnt1 != 0) cnt1--;
    else if (int_send1) begin
      for (int b = 0; b < 4; b++) got1.push_back(int_data1[8*b +: 8]);
      cnt1 = $urandom_range(1, 5);
    end
    if (word_done1) done1++;
  end

  // Reference state for the tagged instance.
  int          ptr_m = 0;
  logic [15:0] seq_m = 16'd0;
  int          dtarget0 = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] hdr_m(input int id, input logic [15:0] s);
    return {8'hA5, 5'd0, 3'(id), s};
  endfunction

  task automatic push_w0(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp0.push_back(w[8*b +: 8]);
  endtask

  task automatic check_logs0();
    chk("byte_count", got0.size(), exp0.size());
    for (int j = 0; j < exp0.size() && j < got0.size(); j++) chk("byte", got0[j], exp0[j]);
    chk("grant_count", gid0.size(), gid_exp0.size());
    for (int j = 0; j < gid_exp0.size() && j < gid0.size(); j++) chk("grant_order", gid0[j], gid_exp0[j]);
    got0.delete(); exp0.delete(); gid0.delete(); gid_exp0.delete();
  endtask

  // Submit all requesters in mask in one cycle; expected service order is ascending distance from ptr_m.
  task automatic wave0(input logic [3:0] mask, input logic [127:0] dat, input int hold_cyc);
    int          order[$];
    int          i, n;
    logic [31:0] first_w;
    logic [3:0]  nm;
    for (int k = 0; k < 4; k++) begin
      i = (ptr_m + k) % 4;
      if (mask[i]) order.push_back(i);
    end
    first_w = hdr_m(order[0], seq_m);
    foreach (order[j]) begin
      push_w0(hdr_m(order[j], seq_m));
      push_w0(dat[32*order[j] +: 32]);
      gid_exp0.push_back(order[j]);
      seq_m = seq_m + 16'd1;
    end
    ptr_m = (order[order.size()-1] + 1) % 4;
    dtarget0 += order.size();

    chk("ready_idle", req_ready0, 4'hF);
    hold0 = (hold_cyc > 0);
    req_valid0 = mask;
    req_data0  = dat;
    tick();
    req_valid0 = 4'd0;
    nm = ~mask;
    chk("captured", req_ready0, nm);
    chk("no_send_yet", int_send0, 1'b0);
    repeat (hold_cyc) begin
      tick();
      chk("held_send", int_send0, 1'b0);
      chk("held_busy", busy0, 1'b0);
    end
    hold0 = 1'b0;
    tick();
    chk("send_rise", int_send0, 1'b1);
    chk("busy_set", busy0, 1'b1);
    chk("grant_id", grant_id0, order[0]);
    chk("first_word", int_data0, first_w);

    n = 0;
    while (done0 < dtarget0 && n < 2000) begin tick(); n++; end
    chk("done_timeout", done0 >= dtarget0, 1'b1);
    tick();
    tick();
    chk("done_pulses", done0, dtarget0);
    chk("seq", seq0, seq_m);
    chk("ready_after", req_ready0, 4'hF);
    chk("busy_after", busy0, 1'b0);
    check_logs0();
  endtask

  initial begin
    int          n, a0;
    logic [31:0] w;

    rst = 1'b1;
    req_valid0 = 4'd0; req_data0 = '0;
    req_valid1 = 4'd0; req_data1 = '0;
    repeat (3) tick();
    chk("rst_ready", req_ready0, 4'hF);
    chk("rst_send", int_send0, 1'b0);
    chk("rst_data", int_data0, 32'd0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_gid", grant_id0, 3'd0);
    chk("rst_done", word_done0, 1'b0);
    chk("rst_seq", seq0, 16'd0);
    chk("rst_ready1", req_ready1, 4'hF);
    chk("rst_send1", int_send1, 1'b0);
    rst = 1'b0;
    tick();

    // Single request from requester 2
    wave0(4'b0100, {32'h0, 32'hDEADBEEF, 64'h0}, 0);

    // Contention starting from pointer 0
    rst = 1'b1; tick(); rst = 1'b0; tick();
    ptr_m = 0; seq_m = 16'd0;
    chk("rst_seq2", seq0, 16'd0);
    wave0(4'b1011, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000}, 0);
    wave0(4'b0011, {32'h0, 32'h0, 32'hBBBB0001, 32'hAAAA0000}, 0);

    for (int r = 0; r < 10; r++)
      wave0(4'($urandom_range(1, 15)), {$urandom, $urandom, $urandom, $urandom}, 0);

    // Downstream busy while slot 0 waits
    wave0(4'b0001, {96'h0, $urandom}, 6);

    // Reset during the data word of requester 1
    a0 = acc0;
    req_valid0 = 4'b0010;
    req_data0  = {64'h0, 32'hCAFE0001, 32'h0};
    tick();
    req_valid0 = 4'd0;
    push_w0(hdr_m(1, seq_m));
    push_w0(32'hCAFE0001);
    n = 0;
    while (acc0 < a0 + 2 && n < 500) begin tick(); n++; end
    chk("data_accept", acc0 >= a0 + 2, 1'b1);
    hold0 = 1'b1;
    rst = 1'b1;
    tick();
    chk("mid_rst_send", int_send0, 1'b0);
    chk("mid_rst_ready", req_ready0, 4'hF);
    chk("mid_rst_seq", seq0, 16'd0);
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_gid", grant_id0, 3'd0);
    rst = 1'b0;
    ptr_m = 0;
    seq_m = 16'd0;
    check_logs0();
    wave0(4'b0001, {96'h0, 32'h0BADF00D}, 7);

    // Sequence wrap
    force u_dut0.seq = 16'hFFFF;
    tick();
    release u_dut0.seq;
    tick();
    chk("seq_preload", seq0, 16'hFFFF);
    seq_m = 16'hFFFF;
    wave0(4'b0100, {32'h0, 32'h5EED5EED, 64'h0}, 0);
    chk("seq_wrapped", seq0, 16'h0000);

    // Untagged instance: data word only
    w = 32'h01020304;
    req_valid1 = 4'b0010;
    req_data1  = {64'h0, w, 32'h0};
    tick();
    req_valid1 = 4'd0;
    chk("t0_captured", req_ready1, 4'b1101);
    tick();
    chk("t0_send", int_send1, 1'b1);
    chk("t0_busy", busy1, 1'b1);
    chk("t0_data", int_data1, w);
    n = 0;
    while (done1 < 1 && n < 500) begin tick(); n++; end
    chk("t0_done_timeout", done1 >= 1, 1'b1);
    tick();
    tick();
    chk("t0_done_pulses", done1, 1);
    chk("t0_byte_count", got1.size(), 4);
    for (int j = 0; j < 4 && j < got1.size(); j++) chk("t0_byte", got1[j], w[8*j +: 8]);
    chk("t0_seq", seq1, 16'd1);
    chk("t0_gid", grant_id1, 3'd1);
    chk("t0_ready", req_ready1, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
